lfsr_share_ctrl: RTL



---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr_step_core.sv | 31 +++
 rtl/lfsr_share_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants, types and the LFSR step rule for lfsr_share_ctrl.
// The x^10+x^7+1 step includes the all-zero lock-up guard.
package lfsr_pkg;

  localparam int LFSR_W      = 10;
  localparam int TAP_HI      = 9;
  localparam int TAP_LO      = 6;
  localparam int LFSR_PERIOD = 1023;

  typedef logic [LFSR_W-1:0] lfsr_t;

  typedef enum logic [1:0] {
    IDLE,
    SERVE,
    RESEED
  } ctrl_state_e;

  // An all-zero state can never leave zero, so the step restarts from the seed instead.
  function automatic lfsr_t lfsr_next(input lfsr_t s, input lfsr_t seed);
    if (s == '0) return seed;
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// 10-bit Fibonacci LFSR register with load and step enable.
// Load wins over step; with neither asserted the state holds.
module lfsr_step_core
  import lfsr_pkg::*;
#(
  parameter lfsr_t SEED = 10'h200
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_step,
  input  logic  i_load,
  input  lfsr_t i_load_val,
  output lfsr_t o_state
);

  lfsr_t r_state;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_load) begin
      r_state <= i_load_val;
    end else if (i_step) begin
      r_state <= lfsr_next(r_state, SEED);
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/lfsr_share_ctrl.sv
// Round-robin sharing of one LFSR among NUM_REQ requesters, with runtime reseed.
// Optional period checker built when LFSR_PERIOD_CHK_EN is defined.
module lfsr_share_ctrl
  import lfsr_pkg::*;
#(
  parameter int    NUM_REQ = 4,
  parameter lfsr_t SEED    = 10'h200
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       rnd_valid,
  output logic [LFSR_W-1:0]          rnd_data,
  output logic [$clog2(NUM_REQ)-1:0] rnd_id,
  input  logic                       seed_load,
  input  logic [LFSR_W-1:0]          seed_val,
  output logic                       busy,
  output logic                       period_wrap
);

  localparam int ID_W = $clog2(NUM_REQ);

  ctrl_state_e          r_state;
  ctrl_state_e          w_state_nxt;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      w_win_idx;
  logic [ID_W-1:0]      w_ptr_nxt;
  logic                 w_win_vld;
  logic                 w_grant;
  logic [NUM_REQ-1:0]   r_gnt;
  lfsr_t                r_rnd_data;
  logic [ID_W-1:0]      r_rnd_id;
  lfsr_t                w_lfsr;
  lfsr_t                w_load_val;

  assign w_load_val = (seed_val == '0) ? SEED : seed_val;

  lfsr_step_core #(
    .SEED (SEED)
  ) u_core (
    .clk        (clk),
    .rst        (rst),
    .i_step     (w_grant),
    .i_load     (seed_load),
    .i_load_val (w_load_val),
    .o_state    (w_lfsr)
  );

  // Search begins at r_ptr (one past the last winner) and wraps to 0.
  always_comb begin
    int idx;
    idx       = 0;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(r_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_win_vld && req[ID_W'(idx)]) begin
        w_win_vld = 1'b1;
        w_win_idx = ID_W'(idx);
      end
    end
  end

  assign w_ptr_nxt = (w_win_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_win_idx + 1'b1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    if (seed_load) begin
      w_state_nxt = RESEED;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_win_vld) begin
            w_state_nxt = SERVE;
            w_grant     = 1'b1;
          end
        end
        SERVE: begin
          if (w_win_vld) w_grant = 1'b1;
          else           w_state_nxt = IDLE;
        end
        RESEED: begin
          w_state_nxt = w_win_vld ? SERVE : IDLE;
          w_grant     = w_win_vld;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_gnt      <= '0;
      r_rnd_data <= '0;
      r_rnd_id   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_gnt   <= '0;
      if (w_grant) begin
        r_gnt      <= NUM_REQ'(1) << w_win_idx;
        r_rnd_data <= w_lfsr;
        r_rnd_id   <= w_win_idx;
        r_ptr      <= w_ptr_nxt;
      end
    end
  end

  assign gnt       = r_gnt;
  assign rnd_valid = |r_gnt;
  assign rnd_data  = r_rnd_data;
  assign rnd_id    = r_rnd_id;
  assign busy      = (r_state == RESEED);

`ifdef LFSR_PERIOD_CHK_EN
  logic [LFSR_W-1:0] r_step_cnt;
  lfsr_t             r_seed_ref;
  logic              r_period_wrap;

  // The count runs modulo the period so every later wrap also lands on 1023.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_step_cnt    <= '0;
      r_seed_ref    <= SEED;
      r_period_wrap <= 1'b0;
    end else if (seed_load) begin
      r_step_cnt    <= '0;
      r_seed_ref    <= w_load_val;
      r_period_wrap <= 1'b0;
    end else begin
      r_period_wrap <= w_grant && (lfsr_next(w_lfsr, SEED) == r_seed_ref);
      if (w_grant) begin
        r_step_cnt <= (r_step_cnt == LFSR_W'(LFSR_PERIOD)) ? LFSR_W'(1) : r_step_cnt + 1'b1;
      end
    end
  end

  assign period_wrap = r_period_wrap;

`ifndef SYNTHESIS
  a_period_len : assert property (@(posedge clk) disable iff (rst)
    r_period_wrap |-> (r_step_cnt == LFSR_W'(LFSR_PERIOD)))
    else $error("period_wrap with step count %0d", r_step_cnt);
`endif
`else
  assign period_wrap = 1'b0;
`endif

endmodule
